// File: rtl/program_loader.sv
// Programmer-interface sequencer: requests CU programming mode, streams a nibble image into
// program memory over valid/ready, then releases the CPU; reports checksum, done and timeouts.
module program_loader #(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic                            load_valid_i,
    input  logic [REGISTER_WIDTH-1:0]       load_data_i,
    output logic                            load_ready_o,
    output logic                            p_programm_o,
    input  logic                            p_active_i,
    output logic                            p_write_en_mem_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
    output logic [REGISTER_WIDTH-1:0]       p_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [REGISTER_WIDTH-1:0]       checksum_o
);
    localparam int RW = REGISTER_WIDTH;
    localparam int AW = MEMORY_ADDRESS_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST_ADDR  = '1;
    localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_RECV,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] stall_cnt;
    logic [TW-1:0] stall_cnt_nxt;
    logic [AW-1:0] address_nxt;
    logic [RW-1:0] data_nxt;
    logic [RW-1:0] checksum_nxt;
    logic          error_nxt;
    logic          handshake;
    logic          stalled;
    logic          expired;

    // load_ready_o is only ever high while in RECV, so it alone qualifies the handshake.
    assign handshake = load_valid_i & load_ready_o;
    assign stalled   = ((state == S_REQUEST) && !p_active_i) ||
                       ((state == S_RECV) && !handshake);
    assign expired   = stalled && (stall_cnt == STALL_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        address_nxt   = p_address_o;
        data_nxt      = p_data_o;
        checksum_nxt  = checksum_o;
        error_nxt     = error_o;

        case (state)
            S_IDLE: begin
                address_nxt = '0;
                data_nxt    = '0;
                if (start_i) begin
                    state_nxt     = S_REQUEST;
                    stall_cnt_nxt = '0;
                    checksum_nxt  = '0;
                    error_nxt     = 1'b0;
                end
            end
            S_REQUEST: begin
                if (p_active_i) begin
                    state_nxt     = S_RECV;
                    stall_cnt_nxt = '0;
                end else if (expired) begin
                    state_nxt   = S_IDLE;
                    error_nxt   = 1'b1;
                    address_nxt = '0;
                    data_nxt    = '0;
                end else begin
                    stall_cnt_nxt = stall_cnt + TW'(1);
                end
            end
            S_RECV: begin
                if (handshake) begin
                    state_nxt     = S_WRITE;
                    stall_cnt_nxt = '0;
                    data_nxt      = load_data_i;
                    checksum_nxt  = checksum_o ^ load_data_i;
                end else if (expired) begin
                    state_nxt   = S_IDLE;
                    error_nxt   = 1'b1;
                    address_nxt = '0;
                    data_nxt    = '0;
                end else begin
                    stall_cnt_nxt = stall_cnt + TW'(1);
                end
            end
            S_WRITE: begin
                stall_cnt_nxt = '0;
                if (p_address_o == LAST_ADDR) begin
                    state_nxt = S_RELEASE;
                end else begin
                    state_nxt   = S_RECV;
                    address_nxt = p_address_o + AW'(1);
                end
            end
            S_RELEASE: begin
                state_nxt   = S_IDLE;
                address_nxt = '0;
                data_nxt    = '0;
            end
            default: begin
                state_nxt   = S_IDLE;
                address_nxt = '0;
                data_nxt    = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop aligned with its state.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_i) begin
            state            <= S_IDLE;
            stall_cnt        <= '0;
            load_ready_o     <= 1'b0;
            p_programm_o     <= 1'b0;
            p_write_en_mem_o <= 1'b0;
            p_address_o      <= '0;
            p_data_o         <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            error_o          <= 1'b0;
            checksum_o       <= '0;
        end else begin
            state            <= state_nxt;
            stall_cnt        <= stall_cnt_nxt;
            p_address_o      <= address_nxt;
            p_data_o         <= data_nxt;
            checksum_o       <= checksum_nxt;
            error_o          <= error_nxt;
            load_ready_o     <= (state_nxt == S_RECV);
            p_programm_o     <= (state_nxt == S_REQUEST) || (state_nxt == S_RECV) ||
                                (state_nxt == S_WRITE);
            p_write_en_mem_o <= (state_nxt == S_WRITE);
            busy_o           <= (state_nxt != S_IDLE);
            done_o           <= (state_nxt == S_RELEASE);
        end
    end

endmodule
